// File: rtl/nios2_oci_tm_pkg.sv
// Shared constants and helpers for the OCI trace-message packer.
package nios2_oci_tm_pkg;

    // Width needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DROP_CNT_W = 16;

    // Channel index assignment in the default three-channel build.
    localparam int TM_DTM = 0;
    localparam int TM_ATM = 1;
    localparam int TM_ITM = 2;

endpackage

// File: rtl/nios2_oci_tm_compact.sv
// Counts the valid trace channels and gives each channel its slot offset
// within the compacted group (number of valid lower-index channels).
module nios2_oci_tm_compact
    import nios2_oci_tm_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = cnt_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0]            tm_valid,
    output logic [CNT_W-1:0]             count,
    output logic [NUM_CH-1:0][CNT_W-1:0] offset
);

    logic [CNT_W-1:0] running;

    // Running prefix sum over channels in ascending index order.
    always_comb begin
        running = '0;
        offset  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            offset[i] = running;
            running   = running + CNT_W'(tm_valid[i]);
        end
        count = running;
    end

endmodule

// File: rtl/nios2_oci_tm_packer.sv
// Trace-message packer: compacts each cycle's valid channel words into a
// circular buffer, drains one word per cycle through a valid/ready port and
// accounts for groups that did not fit.
module nios2_oci_tm_packer
    import nios2_oci_tm_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 36,
    parameter int DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             tm_valid,
    input  logic [NUM_CH*DATA_W-1:0]      tm_data,
    output logic [cnt_w(NUM_CH)-1:0]      compute_tm_count,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]    fill_level,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [DROP_CNT_W-1:0]         drop_count
);

    localparam int CNT_W  = cnt_w(NUM_CH);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam int DSUM_W = DROP_CNT_W + 1;

    logic [DATA_W-1:0]             mem [DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [NUM_CH-1:0][CNT_W-1:0]  offset;
    logic [CNT_W-1:0]              count;
    logic [FILL_W-1:0]             free_slots;
    logic [FILL_W-1:0]             written;
    logic [FILL_W-1:0]             fill_next;
    logic                          accept;
    logic                          drop;
    logic                          pop;
    logic [DROP_CNT_W-1:0]         drop_base;
    logic [DSUM_W-1:0]             drop_sum;
    logic [DROP_CNT_W-1:0]         drop_next;

    nios2_oci_tm_compact #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_compact (
        .tm_valid (tm_valid),
        .count    (count),
        .offset   (offset)
    );

    assign compute_tm_count = count;
    assign rd_valid         = (fill_level != '0);
    assign rd_data          = mem[rd_ptr];
    assign pop              = rd_valid & rd_ready;

    // Admission is judged against the registered occupancy only, so a pop in
    // the same cycle never makes room for the incoming group.
    always_comb begin
        free_slots = FILL_W'(DEPTH) - fill_level;
        accept     = (FILL_W'(count) <= free_slots);
        drop       = (count != '0) && !accept;
        written    = accept ? FILL_W'(count) : '0;
        fill_next  = fill_level + written - FILL_W'(pop);
    end

    // Saturating drop counter; a clear in the same cycle restarts from zero
    // so the dropping group is still accounted for.
    always_comb begin
        drop_base = clear_overflow ? '0 : drop_count;
        drop_sum  = {1'b0, drop_base} + DSUM_W'(count);
        drop_next = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    // Buffer storage: each valid channel lands at wr_ptr plus its offset.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tm_valid[i]) begin
                    mem[wr_ptr + PTR_W'(offset[i])] <= tm_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Pointers, occupancy and overflow accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(count);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fill_level <= fill_next;
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_next;
            end else if (clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_oci_tm_packer.sv
// Directed and scoreboard-driven checks for the trace-message packer.
module tb_nios2_oci_tm_packer;
    import nios2_oci_tm_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 36;
    localparam int DEPTH  = 16;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH-1:0]        tm_valid;
    logic [NUM_CH*DATA_W-1:0] tm_data;
    logic [1:0]               compute_tm_count;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [DATA_W-1:0]        rd_data;
    logic [4:0]               fill_level;
    logic                     overflow;
    logic                     clear_overflow;
    logic [15:0]              drop_count;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sb [$];

    nios2_oci_tm_packer #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .tm_valid         (tm_valid),
        .tm_data          (tm_data),
        .compute_tm_count (compute_tm_count),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_data          (rd_data),
        .fill_level       (fill_level),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow),
        .drop_count       (drop_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_CH*DATA_W-1:0] mkgroup(input int k);
        logic [NUM_CH*DATA_W-1:0] g;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            g[ch*DATA_W +: DATA_W] = 36'h5_0000_0000 + DATA_W'(k * 4 + ch);
        end
        return g;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d,
                                 input logic rr, input logic clr);
        tm_valid       = v;
        tm_data        = d;
        rd_ready       = rr;
        clear_overflow = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic popExpect(input string tag, input logic [DATA_W-1:0] exp);
        checkOutput({tag, "_valid"}, 64'(rd_valid), 64'd1);
        checkOutput({tag, "_data"}, 64'(rd_data), 64'(exp));
        applyStimulus('0, '0, 1'b1, 1'b0);
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM_CH-1:0]        v;
        logic [NUM_CH*DATA_W-1:0] d;
        logic                     rr;
        int                       cnt;

        reset = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        doReset();
        $display("[TB] reset state");
        checkOutput("rst_fill", 64'(fill_level), 64'd0);
        checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_drop", 64'(drop_count), 64'd0);

        $display("[TB] full group and in-order drain");
        d = '0;
        d[0*DATA_W +: DATA_W] = 36'hA_AAAA_0001;
        d[1*DATA_W +: DATA_W] = 36'hB_BBBB_0002;
        d[2*DATA_W +: DATA_W] = 36'hC_CCCC_0003;
        applyStimulus(3'b111, d, 1'b0, 1'b0);
        #1;
        checkOutput("cnt_111", 64'(compute_tm_count), 64'd3);
        checkOutput("no_bypass", 64'(rd_valid), 64'd0);
        tick();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("fill_3", 64'(fill_level), 64'd3);
        popExpect("popA", 36'hA_AAAA_0001);
        popExpect("popB", 36'hB_BBBB_0002);
        popExpect("popC", 36'hC_CCCC_0003);
        checkOutput("empty_after_abc", 64'(rd_valid), 64'd0);
        checkOutput("fill_0", 64'(fill_level), 64'd0);

        $display("[TB] sparse compaction");
        d = '0;
        d[0*DATA_W +: DATA_W] = 36'h0_D000_0000;
        d[2*DATA_W +: DATA_W] = 36'h0_D000_0002;
        applyStimulus(3'b101, d, 1'b0, 1'b0);
        #1;
        checkOutput("cnt_101", 64'(compute_tm_count), 64'd2);
        tick();
        d = '0;
        d[1*DATA_W +: DATA_W] = 36'h0_E000_0001;
        applyStimulus(3'b010, d, 1'b0, 1'b0);
        #1;
        checkOutput("cnt_010", 64'(compute_tm_count), 64'd1);
        tick();
        applyStimulus(3'b000, '1, 1'b0, 1'b0);
        #1;
        checkOutput("cnt_000", 64'(compute_tm_count), 64'd0);
        tick();
        d = '0;
        d[1*DATA_W +: DATA_W] = 36'h0_F000_0001;
        d[2*DATA_W +: DATA_W] = 36'h0_F000_0002;
        applyStimulus(3'b110, d, 1'b0, 1'b0);
        #1;
        checkOutput("cnt_110", 64'(compute_tm_count), 64'd2);
        tick();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("fill_5", 64'(fill_level), 64'd5);
        popExpect("pop_d0", 36'h0_D000_0000);
        popExpect("pop_d2", 36'h0_D000_0002);
        popExpect("pop_e1", 36'h0_E000_0001);
        popExpect("pop_f1", 36'h0_F000_0001);
        popExpect("pop_f2", 36'h0_F000_0002);

        $display("[TB] overflow and all-or-nothing admission");
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b111, mkgroup(k), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(3'b011, mkgroup(4), 1'b0, 1'b0);
        tick();
        checkOutput("fill_14", 64'(fill_level), 64'd14);
        applyStimulus(3'b111, mkgroup(5), 1'b0, 1'b0);
        tick();
        checkOutput("drop3_fill", 64'(fill_level), 64'd14);
        checkOutput("drop3_ovf", 64'(overflow), 64'd1);
        checkOutput("drop3_cnt", 64'(drop_count), 64'd3);
        applyStimulus(3'b011, mkgroup(6), 1'b0, 1'b0);
        tick();
        checkOutput("fill_16", 64'(fill_level), 64'd16);
        checkOutput("fit2_cnt", 64'(drop_count), 64'd3);

        applyStimulus(3'b001, mkgroup(7), 1'b1, 1'b0);
        tick();
        checkOutput("noCredit_fill", 64'(fill_level), 64'd15);
        checkOutput("noCredit_drop", 64'(drop_count), 64'd4);
        checkOutput("noCredit_ovf", 64'(overflow), 64'd1);

        applyStimulus(3'b001, mkgroup(8), 1'b0, 1'b0);
        tick();
        checkOutput("refill_16", 64'(fill_level), 64'd16);
        applyStimulus(3'b001, mkgroup(9), 1'b0, 1'b0);
        tick();
        checkOutput("drop_5", 64'(drop_count), 64'd5);

        applyStimulus(3'b111, mkgroup(10), 1'b0, 1'b1);
        tick();
        checkOutput("clrDrop_ovf", 64'(overflow), 64'd1);
        checkOutput("clrDrop_cnt", 64'(drop_count), 64'd3);
        applyStimulus(3'b000, '0, 1'b0, 1'b1);
        tick();
        checkOutput("clr_ovf", 64'(overflow), 64'd0);
        checkOutput("clr_cnt", 64'(drop_count), 64'd0);

        $display("[TB] drop counter saturation");
        applyStimulus(3'b111, mkgroup(11), 1'b0, 1'b0);
        for (int k = 0; k < 21845; k++) begin
            tick();
        end
        checkOutput("sat_reach", 64'(drop_count), 64'hFFFF);
        tick();
        checkOutput("sat_hold", 64'(drop_count), 64'hFFFF);
        checkOutput("sat_fill", 64'(fill_level), 64'd16);
        applyStimulus('0, '0, 1'b0, 1'b0);
        popExpect("pop_g0c1", 36'h5_0000_0001);
        popExpect("pop_g0c2", 36'h5_0000_0002);

        $display("[TB] random stream with wrap and mid-stream reset");
        doReset();
        sb.delete();
        for (int step = 0; step < 40; step++) begin
            v  = NUM_CH'($urandom_range(7));
            rr = 1'($urandom_range(1));
            d  = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                d[ch*DATA_W +: DATA_W] = {4'($urandom_range(15)), 32'($urandom())};
            end
            cnt = 0;
            for (int ch = 0; ch < NUM_CH; ch++) cnt += int'(v[ch]);
            if (sb.size() + cnt > DEPTH) begin
                v   = '0;
                cnt = 0;
            end
            checkOutput("stream_fill", 64'(fill_level), 64'(sb.size()));
            checkOutput("stream_valid", 64'(rd_valid), 64'(sb.size() != 0));
            if (step == 20) begin
                reset = 1'b1;
                applyStimulus(3'b111, d, rr, 1'b0);
                tick();
                reset = 1'b0;
                sb.delete();
                checkOutput("midrst_valid", 64'(rd_valid), 64'd0);
                checkOutput("midrst_fill", 64'(fill_level), 64'd0);
            end else begin
                applyStimulus(v, d, rr, 1'b0);
                #1;
                checkOutput("stream_cnt", 64'(compute_tm_count), 64'(cnt));
                if (rr && sb.size() != 0) begin
                    checkOutput("stream_data", 64'(rd_data), 64'(sb[0]));
                    void'(sb.pop_front());
                end
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (v[ch]) sb.push_back(d[ch*DATA_W +: DATA_W]);
                end
                tick();
            end
        end
        applyStimulus('0, '0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            popExpect("drain", sb.pop_front());
        end
        checkOutput("stream_empty", 64'(rd_valid), 64'd0);
        checkOutput("stream_no_ovf", 64'(overflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2_oci_tm_packer.md
# nios2_oci_tm_packer

Parametrised trace-message packer for the Nios II OCI trace path. Each cycle it counts the asserted trace channels (instruction, address, data, …), compacts their words into a circular trace buffer in channel order, and drains one word per cycle through a valid/ready read port. It generalises the fixed 3-channel message count to NUM_CH channels, and adds buffering, fill tracking and overflow accounting. It sits between the trace-message generators and the trace-memory/off-chip trace interface.

## Interface
- NUM_CH, 3: number of trace channels (1..8); channel 0 = dtm, 1 = atm, 2 = itm in the default build.
- DATA_W, 36: trace word width.
- DEPTH, 16: buffer entries; power of two, DEPTH >= NUM_CH.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- tm_valid  in  NUM_CH  per-channel message valid, this cycle.
- tm_data  in  NUM_CH*DATA_W  channel i word at bits [i*DATA_W +: DATA_W].
- compute_tm_count  out  CNT_W  combinational popcount of tm_valid; CNT_W = $clog2(NUM_CH+1).
- rd_valid  out  1  buffer non-empty.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_data  out  DATA_W  oldest buffered word.
- fill_level  out  $clog2(DEPTH+1)  registered occupancy.
- overflow  out  1  sticky: at least one group dropped.
- clear_overflow  in  1  clears overflow and drop_count.
- drop_count  out  16  saturating count of dropped words.

## Operation
- Group: the set of channels with tm_valid=1 in a cycle; size = compute_tm_count.
- Compaction: valid words written in ascending channel index to wr_ptr, wr_ptr+1, …, modulo DEPTH; invalid channels consume no slot.
- Admission is all-or-nothing: free = DEPTH - fill_level (registered value; a same-cycle read gives no credit). If count <= free, the whole group is written and wr_ptr advances by count. Otherwise nothing is written, overflow is set, and drop_count increments by count, saturating at 16'hFFFF.
- Read: rd_valid = (fill_level != 0); rd_data = mem[rd_ptr]. A pop (rd_valid & rd_ready) advances rd_ptr by 1. rd_ready while empty is ignored.
- fill_level_next = fill_level + written - pop. Push and pop in the same cycle are both applied.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty are resolved by fill_level, not by pointer compare.
- clear_overflow zeroes overflow and drop_count. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_count = count of that group.
- count = 0 cycles never set overflow, even when the buffer is full.

## Timing
- compute_tm_count: zero latency (combinational).
- A word written in cycle N appears at rd_data / rd_valid in cycle N+1 at the earliest. There is no bypass when the buffer is empty.
- fill_level, overflow and drop_count update on the clk edge following the event.
- Reset, including mid-operation: wr_ptr=0, rd_ptr=0, fill_level=0, rd_valid=0, overflow=0, drop_count=0. Buffer contents are not reset; rd_data is don't-care while rd_valid=0. tm_valid is ignored during the reset cycle.

## Structure
- Package nios2_oci_tm_pkg holds:
  - cnt_w(n) function
  - DROP_CNT_W = 16 constant
  - channel index constants TM_DTM=0, TM_ATM=1, TM_ITM=2
- Sub-module nios2_oci_tm_compact (combinational): takes tm_valid and produces the popcount and per-channel prefix offset (number of lower-index valid channels). The top level uses these offsets to form write addresses wr_ptr+offset[i].
- Storage is a flat register array with NUM_CH write ports and one read port. No RAM inference is required at the default depth.

## Test plan
- Defaults; tm_valid 3'b111, data A/B/C on ch0/1/2, rd_ready=0 -> compute_tm_count=3; next cycle fill_level=3, rd_data=A; popping returns A, B, C in order, then rd_valid=0.
- tm_valid sequence 3'b101, 3'b010, 3'b000, 3'b110 -> counts 2, 1, 0, 2; buffer order ch0, ch2, ch1, ch1, ch2; fill_level=5.
- Fill to 14 with rd_ready=0, then tm_valid=3'b111 -> group dropped, fill stays 14, overflow=1, drop_count=3; then tm_valid=3'b011 -> accepted, fill=16.
- At fill=16, tm_valid=3'b001 with rd_ready=1 in the same cycle -> drop (no read credit), fill=15, drop_count increments by 1.
- overflow=1 and drop_count=5; clear_overflow together with a dropping 3-word group -> overflow=1, drop_count=3. Clear alone the following cycle -> overflow=0, drop_count=0.
- Wrap-around: stream 40 groups of random tm_valid with random rd_ready (no overflow) -> output order matches the scoreboard. Assert reset mid-stream -> next cycle rd_valid=0, fill_level=0, and the stream resumes correctly.
